div_scan_ctrl: RTL and testbench

Sequencer for the nibble divisibility checker (divisible by 3 or 4). On a start request it latches an inclusive range [lo, hi] and steps the checker through every value in the range, one value per clock. It collects a hit count, a per-value hit mask and the first hit, then signals completion with a one-cycle done pulse. It sits between a host/test controller and the combinational checker instance, which it drives through dedicated chk_* ports.

---
 rtl/div_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_div_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scan_ctrl.sv
// Range sequencer for the nibble divisibility checker: walks chk_val over [lo, hi]
// one value per clock and accumulates hit count, hit mask and the first hit.
module div_scan_ctrl #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [W-1:0]      lo,
    input  logic [W-1:0]      hi,
    output logic [W-1:0]      chk_val,
    output logic              chk_vld,
    input  logic              chk_div,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted,
    output logic [W:0]        hit_cnt,
    output logic [2**W-1:0]   hit_mask,
    output logic [W-1:0]      first_hit,
    output logic              first_vld,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      cur_q, cur_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W:0]        hit_cnt_q, hit_cnt_d;
    logic [2**W-1:0]   hit_mask_q, hit_mask_d;
    logic [W-1:0]      first_hit_q, first_hit_d;
    logic              first_vld_q, first_vld_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            hi_q        <= '0;
            hit_cnt_q   <= '0;
            hit_mask_q  <= '0;
            first_hit_q <= '0;
            first_vld_q <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_mask_q  <= hit_mask_d;
            first_hit_q <= first_hit_d;
            first_vld_q <= first_vld_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
        end
    end

    // Control: start is a level sampled only in IDLE (ignored otherwise, no
    // acknowledge); abort is sampled only in SCAN and still lets that cycle's
    // checker result count. Completion is the single-cycle done pulse.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        hit_cnt_d   = hit_cnt_q;
        hit_mask_d  = hit_mask_q;
        first_hit_d = first_hit_q;
        first_vld_d = first_vld_q;
        err_d       = err_q;
        aborted_d   = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_d        = hi;
                    cur_d       = lo;
                    hit_cnt_d   = '0;
                    hit_mask_d  = '0;
                    first_hit_d = '0;
                    first_vld_d = 1'b0;
                    aborted_d   = 1'b0;
                    err_d       = (lo > hi);
                    state_d     = (lo > hi) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (chk_div) begin
                    hit_cnt_d         = hit_cnt_q + 1'b1;
                    hit_mask_d[cur_q] = 1'b1;
                    if (!first_vld_q) begin
                        first_hit_d = cur_q;
                        first_vld_d = 1'b1;
                    end
                end
                // Equality test before increment so hi = all-ones never wraps.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (cur_q == hi_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_d = cur_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign chk_vld   = (state_q == S_SCAN);
    assign chk_val   = chk_vld ? cur_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign aborted   = aborted_q;
    assign hit_cnt   = hit_cnt_q;
    assign hit_mask  = hit_mask_q;
    assign first_hit = first_hit_q;
    assign first_vld = first_vld_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_scan_ctrl.sv
// Bench for div_scan_ctrl: per-cycle comparison against an expectation queue built
// from a range-arithmetic model, directed test-plan scans, then randomized scans.
module tb_div_scan_ctrl;

    localparam int W  = 4;
    localparam int NV = 16;

    typedef struct packed {
        logic [W:0]    cnt;
        logic [NV-1:0] mask;
        logic [W-1:0]  first;
        logic          fvld;
        logic          err;
        logic          ab;
    } res_t;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] val;
        logic         busy;
        logic         done;
        logic         chk_res;
        res_t         res;
    } ent_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [W-1:0]  lo, hi;
    logic [W-1:0]  chk_val;
    logic          chk_vld, chk_div;
    logic          busy, done, err, aborted;
    logic [W:0]    hit_cnt;
    logic [NV-1:0] hit_mask;
    logic [W-1:0]  first_hit;
    logic          first_vld;
    logic [1:0]    dbg_state;
    logic [NV-1:0] tbl_v;

    always #5 clk = ~clk;

    assign chk_div = tbl_v[chk_val];

    div_scan_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .chk_val(chk_val), .chk_vld(chk_vld), .chk_div(chk_div),
        .busy(busy), .done(done), .err(err), .aborted(aborted),
        .hit_cnt(hit_cnt), .hit_mask(hit_mask), .first_hit(first_hit),
        .first_vld(first_vld), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];
    res_t held_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: which values get sampled and what they contribute, from plain range arithmetic.
    function automatic res_t model(input int lo_v, input int hi_v, input int abort_k,
                                   input logic [NV-1:0] t);
        res_t r;
        int   last;
        r = '0;
        if (lo_v > hi_v) begin
            r.err = 1'b1;
            return r;
        end
        last = hi_v;
        if (abort_k >= 1 && abort_k <= hi_v - lo_v + 1) begin
            last = lo_v + abort_k - 1;
            r.ab = 1'b1;
        end
        for (int v = lo_v; v <= last; v++) begin
            if (t[v]) begin
                r.cnt     = r.cnt + 1'b1;
                r.mask[v] = 1'b1;
                if (!r.fvld) begin
                    r.first = W'(v);
                    r.fvld  = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0;
            e.chk_res = 1'b1;
            e.res = held_res;
        end
        chk("chk_vld", 32'(chk_vld), 32'(e.vld));
        chk("chk_val", 32'(chk_val), 32'(e.val));
        chk("busy",    32'(busy),    32'(e.busy));
        chk("done",    32'(done),    32'(e.done));
        if (e.chk_res) begin
            chk("hit_cnt",   32'(hit_cnt),   32'(e.res.cnt));
            chk("hit_mask",  32'(hit_mask),  32'(e.res.mask));
            chk("first_hit", 32'(first_hit), 32'(e.res.first));
            chk("first_vld", 32'(first_vld), 32'(e.res.fvld));
            chk("err",       32'(err),       32'(e.res.err));
            chk("aborted",   32'(aborted),   32'(e.res.ab));
        end
        if (e.done) held_res = e.res;
    end

    // ---------------- driver tasks ----------------
    task automatic mid_reset();
        rst_n = 1'b0;
        exp_q.delete();
        held_res = '0;
        #1;
        chk("rst_chk_vld", 32'(chk_vld),   0);
        chk("rst_chk_val", 32'(chk_val),   0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_hit_cnt", 32'(hit_cnt),   0);
        chk("rst_mask",    32'(hit_mask),  0);
        chk("rst_first",   32'(first_vld), 0);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle 0 asserts start; cycles 1..nn are SCAN, nn+1 is done, returns early in nn+2.
    task automatic run_scan(input int lo_v, input int hi_v, input int abort_k,
                            input int restart_k, input int rst_k, output res_t r);
        int   n, nn, rk;
        ent_t e;
        r  = model(lo_v, hi_v, abort_k, tbl_v);
        n  = (lo_v > hi_v) ? 0 : hi_v - lo_v + 1;
        nn = r.ab ? abort_k : n;
        rk = (restart_k > nn) ? 0 : restart_k;
        @(posedge clk);
        #1;
        e = '0; e.chk_res = 1'b1; e.res = held_res;
        exp_q.push_back(e);
        for (int c = 1; c <= nn; c++) begin
            e = '0; e.vld = 1'b1; e.val = W'(lo_v + c - 1); e.busy = 1'b1;
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.chk_res = 1'b1; e.res = r;
        exp_q.push_back(e);
        start = 1'b1;
        lo = W'(lo_v);
        hi = W'(hi_v);
        for (int c = 1; c <= nn + 1; c++) begin
            @(posedge clk);
            #1;
            start = (c == rk);
            abort = (c == abort_k);
            lo = W'($urandom_range(0, NV - 1));
            hi = W'($urandom_range(0, NV - 1));
            if (c == rst_k) begin
                #1 mid_reset();
                return;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        res_t r;
        int   lo_r, hi_r, ab_r, rs_r;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        lo = '0;
        hi = '0;
        for (int v = 0; v < NV; v++) tbl_v[v] = (v % 3 == 0) || (v % 4 == 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_scan(0, 15, 0, 0, 0, r);
        chk("full_cnt",   32'(hit_cnt),   8);
        chk("full_mask",  32'(hit_mask),  32'h9359);
        chk("full_first", 32'(first_hit), 0);
        chk("full_fvld",  32'(first_vld), 1);
        chk("full_err",   32'(err),       0);

        run_scan(5, 7, 0, 0, 0, r);
        chk("sub_cnt",   32'(hit_cnt),   1);
        chk("sub_mask",  32'(hit_mask),  32'h0040);
        chk("sub_first", 32'(first_hit), 6);

        run_scan(15, 15, 0, 0, 0, r);
        chk("top_cnt",  32'(hit_cnt),  1);
        chk("top_mask", 32'(hit_mask), 32'h8000);

        run_scan(5, 5, 0, 0, 0, r);
        chk("one_cnt",  32'(hit_cnt),   0);
        chk("one_fvld", 32'(first_vld), 0);

        run_scan(9, 2, 0, 0, 0, r);
        chk("err_flag", 32'(err),     1);
        chk("err_cnt",  32'(hit_cnt), 0);

        run_scan(0, 15, 5, 3, 0, r);
        chk("abort_flag", 32'(aborted),  1);
        chk("abort_cnt",  32'(hit_cnt),  3);
        chk("abort_mask", 32'(hit_mask), 32'h0019);

        run_scan(0, 15, 0, 0, 6, r);
        run_scan(0, 3, 0, 0, 0, r);
        chk("post_rst_cnt", 32'(hit_cnt), 2);

        repeat (40) begin
            tbl_v = NV'($urandom);
            lo_r  = $urandom_range(0, NV - 1);
            hi_r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NV - 1)
                                               : $urandom_range(lo_r, NV - 1);
            ab_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NV) : 0;
            rs_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NV) : 0;
            run_scan(lo_r, hi_r, ab_r, rs_r, 0, r);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
